// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
//   state_t  : control FSM states (IDLE, RUN, DONE)
//   MODE_ADD : mode encoding for a + b + cin
//   MODE_SUB : mode encoding for a - b - cin (cin acts as borrow-in)
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple adder/subtractor slice.
//   a, b : operand digits
//   mode : MODE_ADD or MODE_SUB
//   ci   : carry-in (add) or borrow-in (sub) into bit 0
//   s    : sum / difference digit
//   co   : carry-out / borrow-out of the digit MSB
//   cm   : carry / borrow into the digit MSB (for signed overflow)
module addsub_digit
    import serial_addsub_pkg::*;
#(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             mode,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             cm
);

    // Ripple the carry/borrow through the digit one bit at a time.
    always_comb begin
        logic c;
        s  = '0;
        cm = ci;
        c  = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            cm   = c;
            s[i] = a[i] ^ b[i] ^ c;
            if (mode == MODE_SUB) begin
                c = (~a[i] & c) | (~a[i] & b[i]) | (b[i] & c);
            end else begin
                c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            end
        end
        co = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: processes a WIDTH-bit operand pair DIGIT
// bits per clock, low digit first, with the carry/borrow held in a chain
// register between cycles. Valid/ready handshake on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b, mode, cin)
//   out_valid, out_ready: result handshake (result, cout, ovf, zero)
//   result              : sum or difference modulo 2^WIDTH
//   cout                : carry-out (add) / borrow-out (sub) of the MSB
//   ovf                 : two's-complement signed overflow
//   zero                : result == 0
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic             mode_q, mode_nxt;
    logic             chain, chain_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             cout_nxt, ovf_nxt, zero_nxt;
    logic             in_ready_nxt, out_valid_nxt;

    logic [IW-1:0]    base;
    logic [DIGIT-1:0] a_dig, b_dig, s_dig;
    logic             co_dig, cm_dig;
    logic [WIDTH-1:0] dmask;
    logic [WIDTH-1:0] res_run;
    logic             last;

    // Select the active digit and merge the new digit into the result.
    always_comb begin
        base    = IW'(cnt) * IW'(DIGIT);
        a_dig   = DIGIT'(a_q >> base);
        b_dig   = DIGIT'(b_q >> base);
        dmask   = WIDTH'({DIGIT{1'b1}}) << base;
        res_run = (result & ~dmask) | (WIDTH'(s_dig) << base);
        last    = (cnt == CW'(N - 1));
    end

    addsub_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a   (a_dig),
        .b   (b_dig),
        .mode(mode_q),
        .ci  (chain),
        .s   (s_dig),
        .co  (co_dig),
        .cm  (cm_dig)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        a_nxt      = a_q;
        b_nxt      = b_q;
        mode_nxt   = mode_q;
        chain_nxt  = chain;
        result_nxt = result;
        cout_nxt   = cout;
        ovf_nxt    = ovf;
        zero_nxt   = zero;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    mode_nxt  = mode;
                    chain_nxt = cin;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                result_nxt = res_run;
                chain_nxt  = co_dig;
                cnt_nxt    = cnt + CW'(1);
                if (last) begin
                    // Carry into MSB xor carry out of MSB equals the
                    // sign-based overflow rule for both add and sub.
                    cout_nxt  = co_dig;
                    ovf_nxt   = co_dig ^ cm_dig;
                    zero_nxt  = (res_run == '0);
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
            chain     <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            mode_q    <= mode_nxt;
            chain     <= chain_nxt;
            result    <= result_nxt;
            cout      <= cout_nxt;
            ovf       <= ovf_nxt;
            zero      <= zero_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule
